// File: rtl/axi_lock_pkg.sv
// Shared types and width helpers for the AXI exclusive-lock controller
// and the grant decoders of the response path.
package axi_lock_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_onehot_enc.sv
// One-hot to binary encoder with a multi-hot flag; covers exactly N inputs.
module axi_onehot_enc
    import axi_lock_pkg::*;
#(
    parameter int unsigned N = 5,
    parameter int unsigned W = clog2_min1(N)
) (
    input  logic [N-1:0] onehot_i,
    output logic [W-1:0] index_o,
    output logic         multi_hot_o
);

    logic seen;

    // OR-ing the indices is exact for one-hot input; multi-hot input is flagged
    // and its index must be ignored by the consumer.
    always_comb begin
        index_o     = '0;
        multi_hot_o = 1'b0;
        seen        = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                if (seen) begin
                    multi_hot_o = 1'b1;
                end
                seen    = 1'b1;
                index_o = index_o | W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_excl_lock_ctrl.sv
// Locking controller for one arbitration tree: pins the tree to the master that
// opened a locked sequence, with a watchdog that frees an abandoned lock.
module axi_excl_lock_ctrl
    import axi_lock_pkg::*;
#(
    parameter int unsigned N_MASTER       = 5,
    parameter int unsigned LOG_MASTER     = clog2_min1(N_MASTER),
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en_i,
    input  logic [N_MASTER-1:0]   master_gnt_i,
    input  logic [N_MASTER-1:0]   master_lock_i,
    output logic                  lock_o,
    output logic [LOG_MASTER-1:0] sel_exclusive_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  error_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    lock_state_e           state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [LOG_MASTER-1:0] gnt_idx;
    logic                  multi_hot;
    logic                  any_gnt;

    assign any_gnt = |master_gnt_i;

    axi_onehot_enc #(
        .N (N_MASTER),
        .W (LOG_MASTER)
    ) u_gnt_enc (
        .onehot_i    (master_gnt_i),
        .index_o     (gnt_idx),
        .multi_hot_o (multi_hot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            lock_o          <= 1'b0;
            sel_exclusive_o <= '0;
            busy_o          <= 1'b0;
            timeout_o       <= 1'b0;
            error_o         <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            error_o   <= multi_hot;
            if (!cfg_en_i) begin
                state  <= IDLE;
                cnt    <= '0;
                lock_o <= 1'b0;
                busy_o <= 1'b0;
            end else if (!multi_hot) begin
                case (state)
                    IDLE: begin
                        if (any_gnt && master_lock_i[gnt_idx]) begin
                            state           <= LOCKED;
                            sel_exclusive_o <= gnt_idx;
                            cnt             <= '0;
                            lock_o          <= 1'b1;
                            busy_o          <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (any_gnt) begin
                            if (gnt_idx == sel_exclusive_o) begin
                                cnt <= '0;
                                if (!master_lock_i[gnt_idx]) begin
                                    state  <= IDLE;
                                    lock_o <= 1'b0;
                                    busy_o <= 1'b0;
                                end
                            end else begin
                                error_o <= 1'b1;
                            end
                        end else if (cnt == CNT_LAST) begin
                            // Release happens before the counter could pass CNT_LAST, so it never wraps.
                            state     <= IDLE;
                            cnt       <= '0;
                            lock_o    <= 1'b0;
                            busy_o    <= 1'b0;
                            timeout_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_excl_lock_ctrl.sv
// Directed and scoreboard-checked random stimulus for axi_excl_lock_ctrl.
module tb_axi_excl_lock_ctrl;

    localparam int unsigned N  = 5;
    localparam int unsigned T  = 8;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_en;
    logic [N-1:0]  gnt;
    logic [N-1:0]  lk;
    logic          lock;
    logic [LW-1:0] sel;
    logic          busy;
    logic          tmo;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    axi_excl_lock_ctrl #(
        .N_MASTER       (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_en_i        (cfg_en),
        .master_gnt_i    (gnt),
        .master_lock_i   (lk),
        .lock_o          (lock),
        .sel_exclusive_o (sel),
        .busy_o          (busy),
        .timeout_o       (tmo),
        .error_o         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs, let one rising edge pass, and return 1 time unit after it.
    task automatic step(input logic [N-1:0] g, input logic [N-1:0] l, input logic en);
        gnt    = g;
        lk     = l;
        cfg_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_lock, input logic [LW-1:0] e_sel,
                             input logic e_tmo, input logic e_err);
        check_eq({tag, ".lock"}, 32'(lock), 32'(e_lock));
        check_eq({tag, ".busy"}, 32'(busy), 32'(e_lock));
        check_eq({tag, ".sel"},  32'(sel),  32'(e_sel));
        check_eq({tag, ".tmo"},  32'(tmo),  32'(e_tmo));
        check_eq({tag, ".err"},  32'(err),  32'(e_err));
    endtask

    // Scoreboard state, expressed as an idle-cycle count rather than a counter value.
    bit            m_locked;
    logic [LW-1:0] m_sel;
    int            m_idle;

    initial begin
        rst = 1'b1; cfg_en = 1'b0; gnt = '0; lk = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all("reset", 1'b0, 3'd0, 1'b0, 1'b0);

        // Basic lock and closing access
        step(5'b00100, 5'b00100, 1'b1);
        check_all("lock_m2", 1'b1, 3'd2, 1'b0, 1'b0);
        step(5'b00100, 5'b00000, 1'b1);
        check_all("close_m2", 1'b0, 3'd2, 1'b0, 1'b0);

        // Watchdog with no grants
        step(5'b00010, 5'b00010, 1'b1);
        check_all("lock_m1", 1'b1, 3'd1, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) begin
            step('0, '0, 1'b1);
            check_all("wd_wait", 1'b1, 3'd1, 1'b0, 1'b0);
        end
        step('0, '0, 1'b1);
        check_all("wd_fire", 1'b0, 3'd1, 1'b1, 1'b0);
        step('0, '0, 1'b1);
        check_all("wd_after", 1'b0, 3'd1, 1'b0, 1'b0);

        // Owner grant at cycle 5 restarts the watchdog
        step(5'b00010, 5'b00010, 1'b1);
        for (int k = 1; k < 5; k++) step('0, '0, 1'b1);
        step(5'b00010, 5'b00010, 1'b1);
        check_all("wd_refresh", 1'b1, 3'd1, 1'b0, 1'b0);
        for (int k = 1; k < T; k++) begin
            step('0, '0, 1'b1);
            check_all("wd2_wait", 1'b1, 3'd1, 1'b0, 1'b0);
        end
        step('0, '0, 1'b1);
        check_all("wd2_fire", 1'b0, 3'd1, 1'b1, 1'b0);

        // Non-owner grant while locked
        step(5'b00001, 5'b00001, 1'b1);
        check_all("lock_m0", 1'b1, 3'd0, 1'b0, 1'b0);
        step(5'b10000, 5'b10000, 1'b1);
        check_all("nonowner", 1'b1, 3'd0, 1'b0, 1'b1);
        step('0, '0, 1'b1);
        check_all("nonowner_end", 1'b1, 3'd0, 1'b0, 1'b0);
        step(5'b00001, 5'b00000, 1'b1);
        check_all("close_m0", 1'b0, 3'd0, 1'b0, 1'b0);

        // Multi-hot grant in IDLE
        step(5'b00011, 5'b00011, 1'b1);
        check_all("multihot", 1'b0, 3'd0, 1'b0, 1'b1);
        step('0, '0, 1'b1);
        check_all("multihot_end", 1'b0, 3'd0, 1'b0, 1'b0);

        // Enable gating
        step(5'b01000, 5'b01000, 1'b0);
        check_all("dis_grant", 1'b0, 3'd0, 1'b0, 1'b0);
        step(5'b01000, 5'b01000, 1'b1);
        check_all("lock_m3", 1'b1, 3'd3, 1'b0, 1'b0);
        step('0, '0, 1'b0);
        check_all("dis_drop", 1'b0, 3'd3, 1'b0, 1'b0);
        for (int k = 0; k < T + 2; k++) begin
            step('0, '0, 1'b1);
            check_all("dis_idle", 1'b0, 3'd3, 1'b0, 1'b0);
        end

        // Asynchronous reset mid-LOCKED
        step(5'b01000, 5'b01000, 1'b1);
        check_all("relock_m3", 1'b1, 3'd3, 1'b0, 1'b0);
        gnt = '0; lk = '0;
        #2 rst = 1'b1;
        #1 check_all("async_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        step('0, '0, 1'b1);
        check_all("post_rst", 1'b0, 3'd0, 1'b0, 1'b0);

        // Random one-hot/idle/multi-hot grants against the scoreboard
        m_locked = 1'b0; m_sel = '0; m_idle = 0;
        for (int c = 0; c < 10000; c++) begin
            logic [N-1:0]  g;
            logic [N-1:0]  l;
            logic [LW-1:0] idx;
            bit            e_tmo, e_err;
            int unsigned   r, a, b;
            r = $urandom_range(0, 9);
            g = '0;
            if (r >= 5 && r <= 8) begin
                g[$urandom_range(0, N - 1)] = 1'b1;
            end else if (r == 9) begin
                a = $urandom_range(0, N - 1);
                b = (a + $urandom_range(1, N - 1)) % N;
                g[a] = 1'b1;
                g[b] = 1'b1;
            end
            l = N'($urandom);
            idx = '0;
            for (int i = 0; i < N; i++) if (g[i]) idx = LW'(i);
            e_tmo = 1'b0; e_err = 1'b0;
            if ($countones(g) > 1) begin
                e_err = 1'b1;
            end else if (!m_locked) begin
                if (g != 0 && l[idx]) begin
                    m_locked = 1'b1; m_sel = idx; m_idle = 0;
                end
            end else if (g != 0) begin
                if (idx == m_sel) begin
                    m_idle = 0;
                    if (!l[idx]) m_locked = 1'b0;
                end else begin
                    e_err = 1'b1;
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin
                    m_locked = 1'b0; m_idle = 0; e_tmo = 1'b1;
                end
            end
            step(g, l, 1'b1);
            check_all("rand", m_locked, m_sel, e_tmo, e_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
